// File: rtl/fifo_rd_ptr_empty.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_ptr_empty
// Purpose  : Read-domain pointer, empty/almost-empty flags, fill count and
//            underflow pulse for an asynchronous FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_ptr_empty #(
    parameter int ADDR_W    = 4,
    parameter int AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wr_ptr_gray,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_accept,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              underflow
);

    localparam logic [ADDR_W:0] c_AE_THRESH = (ADDR_W+1)'(AE_THRESH);

    function automatic logic [ADDR_W:0] gray_to_bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_W:0] r_wq1;
    logic [ADDR_W:0] r_wq2;
    logic [ADDR_W:0] r_rd_bin;
    logic [ADDR_W:0] r_rd_gray;
    logic            r_empty;
    logic            r_almost_empty;
    logic [ADDR_W:0] r_rd_count;
    logic            r_underflow;

    logic [ADDR_W:0] w_wr_bin_s;
    logic            w_rd_inc;
    logic [ADDR_W:0] w_rd_bin_next;
    logic [ADDR_W:0] w_rd_gray_next;
    logic [ADDR_W:0] w_count_next;

    // Only the second synchroniser stage is allowed to feed any logic.
    assign w_wr_bin_s     = gray_to_bin(r_wq2);
    assign w_rd_inc       = rd_en & ~r_empty;
    assign w_rd_bin_next  = r_rd_bin + (ADDR_W+1)'(w_rd_inc);
    assign w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);
    assign w_count_next   = w_wr_bin_s - w_rd_bin_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wq1          <= '0;
            r_wq2          <= '0;
            r_rd_bin       <= '0;
            r_rd_gray      <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_count     <= '0;
            r_underflow    <= 1'b0;
        end else begin
            r_wq1          <= wr_ptr_gray;
            r_wq2          <= r_wq1;
            r_rd_bin       <= w_rd_bin_next;
            r_rd_gray      <= w_rd_gray_next;
            // Full-width Gray compare keeps the wrap bit in the equality test.
            r_empty        <= (w_rd_gray_next == r_wq2);
            r_almost_empty <= (w_count_next <= c_AE_THRESH);
            r_rd_count     <= w_count_next;
            r_underflow    <= rd_en & r_empty;
        end
    end

    assign rd_ptr_gray  = r_rd_gray;
    assign rd_addr      = r_rd_bin[ADDR_W-1:0];
    assign rd_accept    = w_rd_inc;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign rd_count     = r_rd_count;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
